// File: rtl/zc_pkg.sv
// rtl/zc_pkg.sv - shared types and port constants for the zero-crossing detector
package zc_pkg;

    localparam int ZC_DW = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_EVAL,
        S_OUT0,
        S_OUT1,
        S_OUT2,
        S_OUT3,
        S_OUT4
    } zc_state_e;

    localparam logic [1:0] REQ_P1 = 2'b10;

    localparam logic [4:0] OUT_P0 = 5'b00001;
    localparam logic [4:0] OUT_P1 = 5'b00010;
    localparam logic [4:0] OUT_P2 = 5'b00100;
    localparam logic [4:0] OUT_P3 = 5'b01000;
    localparam logic [4:0] OUT_P4 = 5'b10000;

endpackage

// File: rtl/zc_sign_cmp.sv
// rtl/zc_sign_cmp.sv - sign of a sample and crossing against the previous sign
module zc_sign_cmp #(
    parameter int DW = 32
) (
    input  logic [DW-1:0] sample_i,
    input  logic          prev_neg_i,
    input  logic          have_prev_i,
    output logic          neg_o,
    output logic          cross_o,
    output logic          rising_o
);

    // Only the MSB decides the sign; zero counts as positive.
    logic sample_low_unused;
    assign sample_low_unused = ^sample_i[DW-2:0];

    assign neg_o    = sample_i[DW-1];
    assign cross_o  = have_prev_i && (neg_o != prev_neg_i);
    assign rising_o = ~neg_o;

endmodule

// File: rtl/zero_cross_detector.sv
// rtl/zero_cross_detector.sv - streaming zero-crossing detector on a one-hot port I/O protocol
module zero_cross_detector
    import zc_pkg::*;
#(
    parameter int DW = ZC_DW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [DW-1:0] io_in,
    output logic signed [DW-1:0] io_out,
    output logic [1:0]           req_in,
    output logic [4:0]           out_en,
    input  logic                 itr
);

    zc_state_e state_q, state_d;

    logic [DW-1:0] sample_q;
    logic [DW-1:0] idx_q;
    logic [DW-1:0] cnt_q;
    logic [DW-1:0] last_x_q;
    logic          prev_neg_q;
    logic          have_prev_q;
    logic          neg_q;
    logic          rising_q;

    logic [DW-1:0] io_out_q, io_out_d;
    logic [4:0]    out_en_q, out_en_d;
    logic [1:0]    req_q, req_d;

    logic cmp_neg, cmp_cross, cmp_rising;
    logic cur_neg;
    logic itr_unused;

    assign itr_unused = itr;

    zc_sign_cmp #(.DW(DW)) u_sign_cmp (
        .sample_i    (sample_q),
        .prev_neg_i  (prev_neg_q),
        .have_prev_i (have_prev_q),
        .neg_o       (cmp_neg),
        .cross_o     (cmp_cross),
        .rising_o    (cmp_rising)
    );

    // Leaving EVAL straight into OUT4 the latched sign is not yet valid.
    assign cur_neg = (state_q == S_EVAL) ? cmp_neg : neg_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = S_REQ;
            S_REQ:   state_d = S_EVAL;
            S_EVAL:  state_d = cmp_cross ? S_OUT0 : S_OUT4;
            S_OUT0:  state_d = S_OUT1;
            S_OUT1:  state_d = S_OUT2;
            S_OUT2:  state_d = S_OUT3;
            S_OUT3:  state_d = S_OUT4;
            S_OUT4:  state_d = S_REQ;
            default: state_d = S_IDLE;
        endcase
    end

    // Port outputs are decoded from the next state so they appear registered in that state.
    always_comb begin
        req_d    = 2'b00;
        out_en_d = 5'b00000;
        io_out_d = '0;
        case (state_d)
            S_REQ: req_d = REQ_P1;
            S_OUT0: begin
                out_en_d = OUT_P0;
                io_out_d = idx_q;
            end
            S_OUT1: begin
                out_en_d = OUT_P1;
                io_out_d = rising_q ? DW'(1) : {DW{1'b1}};
            end
            S_OUT2: begin
                out_en_d = OUT_P2;
                io_out_d = cnt_q;
            end
            S_OUT3: begin
                out_en_d = OUT_P3;
                io_out_d = idx_q - last_x_q;
            end
            S_OUT4: begin
                out_en_d = OUT_P4;
                io_out_d = cur_neg ? {DW{1'b1}} : DW'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q    <= 2'b00;
            out_en_q <= 5'b00000;
            io_out_q <= '0;
        end else begin
            req_q    <= req_d;
            out_en_q <= out_en_d;
            io_out_q <= io_out_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_q    <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            last_x_q    <= '0;
            prev_neg_q  <= 1'b0;
            have_prev_q <= 1'b0;
            neg_q       <= 1'b0;
            rising_q    <= 1'b0;
        end else begin
            case (state_q)
                S_REQ: sample_q <= io_in;
                S_EVAL: begin
                    neg_q    <= cmp_neg;
                    rising_q <= cmp_rising;
                    if (cmp_cross) begin
                        cnt_q <= cnt_q + DW'(1);
                    end
                end
                S_OUT3: last_x_q <= idx_q;
                S_OUT4: begin
                    prev_neg_q  <= neg_q;
                    have_prev_q <= 1'b1;
                    idx_q       <= idx_q + DW'(1);
                end
                default: ;
            endcase
        end
    end

    assign io_out = io_out_q;
    assign out_en = out_en_q;
    assign req_in = req_q;

endmodule

// File: tb/tb_zero_cross_detector.sv
// tb/tb_zero_cross_detector.sv - directed self-checking bench for zero_cross_detector
module tb_zero_cross_detector;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic signed [31:0] io_in = '0;
    logic signed [31:0] io_out;
    logic [1:0]         req_in;
    logic [4:0]         out_en;
    logic               itr = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int onehot_bad = 0;
    int q0[$], q1[$], q2[$], q3[$], q4[$];
    int c0[$], c4[$], rc[$];
    int feed[$];
    int e[$];

    zero_cross_detector #(.DW(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_in  (io_in),
        .io_out (io_out),
        .req_in (req_in),
        .out_en (out_en),
        .itr    (itr)
    );

    always #5 clk = ~clk;

    function automatic bit same(input int a[$], input int b[$]);
        if (a.size() != b.size()) return 1'b0;
        for (int i = 0; i < a.size(); i++) begin
            if (a[i] != b[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic string fmt(input int a[$]);
        string s;
        s = "{";
        for (int i = 0; i < a.size(); i++) begin
            s = {s, $sformatf("%0d", a[i]), (i == a.size() - 1) ? "" : ","};
        end
        return {s, "}"};
    endfunction

    task automatic step();
        @(negedge clk);
        cyc++;
        if (!$onehot0(out_en)) onehot_bad++;
        case (out_en)
            5'b00001: begin q0.push_back(int'(io_out)); c0.push_back(cyc); end
            5'b00010: q1.push_back(int'(io_out));
            5'b00100: q2.push_back(int'(io_out));
            5'b01000: q3.push_back(int'(io_out));
            5'b10000: begin q4.push_back(int'(io_out)); c4.push_back(cyc); end
            default: ;
        endcase
        if (req_in == 2'b10) begin
            rc.push_back(cyc);
            if (feed.size() > 0) io_in = feed.pop_front();
        end
    endtask

    task automatic clear();
        q0.delete(); q1.delete(); q2.delete(); q3.delete(); q4.delete();
        c0.delete(); c4.delete(); rc.delete(); feed.delete();
        onehot_bad = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear();
        repeat (5) step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        int bad;
        rst = 1'b1;
        clear();
        repeat (5) step();
        checks++;
        if (out_en !== 5'b0) begin errors++; $display("FAIL rst_out_en: got %b want 00000", out_en); end
        checks++;
        if (req_in !== 2'b0) begin errors++; $display("FAIL rst_req_in: got %b want 00", req_in); end
        checks++;
        if (io_out !== 32'sd0) begin errors++; $display("FAIL rst_io_out: got %0d want 0", io_out); end
        repeat (10) feed.push_back(9);
        rst = 1'b0;
        step();
        checks++;
        if (req_in !== 2'b10) begin errors++; $display("FAIL first_req: got %b want 10", req_in); end
        repeat (12) step();
        bad = 0;
        for (int i = 1; i < rc.size(); i++) if (rc[i] - rc[i-1] != 3) bad++;
        checks++;
        if (rc.size() != 5 || bad != 0) begin
            errors++;
            $display("FAIL req_spacing: got %0d requests, %0d bad gaps, want 5 requests, 0 bad gaps", rc.size(), bad);
        end
    endtask

    task automatic test_crossings();
        do_reset();
        feed = '{5, 3, -2, -7, 4};
        for (int i = 0; i < 100 && q4.size() < 5; i++) step();
        checks++;
        if (q4.size() != 5) begin errors++; $display("FAIL xing_timeout: got %0d port4 writes want 5", q4.size()); end
        e = '{2, 4};
        checks++;
        if (!same(q0, e)) begin errors++; $display("FAIL xing_port0: got %s want %s", fmt(q0), fmt(e)); end
        e = '{-1, 1};
        checks++;
        if (!same(q1, e)) begin errors++; $display("FAIL xing_port1: got %s want %s", fmt(q1), fmt(e)); end
        e = '{1, 2};
        checks++;
        if (!same(q2, e)) begin errors++; $display("FAIL xing_port2: got %s want %s", fmt(q2), fmt(e)); end
        e = '{2, 2};
        checks++;
        if (!same(q3, e)) begin errors++; $display("FAIL xing_port3: got %s want %s", fmt(q3), fmt(e)); end
        e = '{1, 1, -1, -1, 1};
        checks++;
        if (!same(q4, e)) begin errors++; $display("FAIL xing_port4: got %s want %s", fmt(q4), fmt(e)); end
        checks++;
        if (rc.size() < 4 || c0.size() < 1 || c4.size() < 3 ||
            c4[0] - rc[0] != 2 || c0[0] - rc[2] != 2 || c4[2] - rc[2] != 6 || rc[3] - rc[2] != 7) begin
            errors++;
            $display("FAIL xing_latency: req %s port0 %s port4 %s want port4-req 2/6, port0-req 2, crossing period 7",
                     fmt(rc), fmt(c0), fmt(c4));
        end
    endtask

    task automatic test_zero();
        do_reset();
        feed = '{0, -1, 0};
        for (int i = 0; i < 60 && q4.size() < 3; i++) step();
        e = '{1, 2};
        checks++;
        if (!same(q0, e)) begin errors++; $display("FAIL zero_port0: got %s want %s", fmt(q0), fmt(e)); end
        e = '{-1, 1};
        checks++;
        if (!same(q1, e)) begin errors++; $display("FAIL zero_port1: got %s want %s", fmt(q1), fmt(e)); end
        e = '{1, 1};
        checks++;
        if (!same(q3, e)) begin errors++; $display("FAIL zero_port3: got %s want %s", fmt(q3), fmt(e)); end
        e = '{1, -1, 1};
        checks++;
        if (!same(q4, e)) begin errors++; $display("FAIL zero_port4: got %s want %s", fmt(q4), fmt(e)); end
    endtask

    task automatic test_steady();
        int bad_val;
        int bad_gap;
        do_reset();
        repeat (1000) feed.push_back(7);
        for (int i = 0; i < 3100 && q4.size() < 1000; i++) step();
        checks++;
        if (q4.size() != 1000) begin errors++; $display("FAIL steady_count: got %0d want 1000", q4.size()); end
        checks++;
        if (q0.size() + q1.size() + q2.size() + q3.size() != 0) begin
            errors++;
            $display("FAIL steady_no_xing: got %0d crossing writes want 0", q0.size() + q1.size() + q2.size() + q3.size());
        end
        bad_val = 0;
        bad_gap = 0;
        for (int i = 0; i < q4.size(); i++) if (q4[i] != 1) bad_val++;
        for (int i = 1; i < c4.size(); i++) if (c4[i] - c4[i-1] != 3) bad_gap++;
        checks++;
        if (bad_val != 0) begin errors++; $display("FAIL steady_value: got %0d non-1 values want 0", bad_val); end
        checks++;
        if (bad_gap != 0) begin errors++; $display("FAIL steady_spacing: got %0d gaps not 3 want 0", bad_gap); end
        checks++;
        if (onehot_bad != 0) begin errors++; $display("FAIL steady_onehot: got %0d bad cycles want 0", onehot_bad); end
    endtask

    task automatic test_reset_abort();
        int bad;
        do_reset();
        feed = '{-5};
        for (int i = 0; i < 10 && rc.size() < 1; i++) step();
        step();
        rst = 1'b1;
        bad = 0;
        repeat (3) begin
            step();
            if (out_en !== 5'b0 || req_in !== 2'b0 || io_out !== 32'sd0) bad++;
        end
        checks++;
        if (bad != 0 || q4.size() != 0) begin
            errors++;
            $display("FAIL abort_quiet: got %0d active cycles, %0d port4 writes want 0, 0", bad, q4.size());
        end
        clear();
        feed = '{3, -1};
        rst = 1'b0;
        for (int i = 0; i < 50 && q4.size() < 2; i++) step();
        e = '{1, -1};
        checks++;
        if (!same(q4, e)) begin errors++; $display("FAIL abort_port4: got %s want %s", fmt(q4), fmt(e)); end
        e = '{1};
        checks++;
        if (!same(q0, e)) begin errors++; $display("FAIL abort_idx: got %s want %s", fmt(q0), fmt(e)); end
        checks++;
        if (!same(q2, e)) begin errors++; $display("FAIL abort_cnt: got %s want %s", fmt(q2), fmt(e)); end
    endtask

    task automatic test_extremes();
        int min_v;
        min_v = 32'sh80000000;
        do_reset();
        feed.push_back(min_v);
        feed.push_back(2147483647);
        for (int i = 0; i < 60 && q4.size() < 2; i++) step();
        e = '{1};
        checks++;
        if (!same(q0, e)) begin errors++; $display("FAIL ext_port0: got %s want %s", fmt(q0), fmt(e)); end
        checks++;
        if (!same(q1, e)) begin errors++; $display("FAIL ext_port1: got %s want %s", fmt(q1), fmt(e)); end
        checks++;
        if (!same(q2, e)) begin errors++; $display("FAIL ext_port2: got %s want %s", fmt(q2), fmt(e)); end
        checks++;
        if (!same(q3, e)) begin errors++; $display("FAIL ext_port3: got %s want %s", fmt(q3), fmt(e)); end
        e = '{-1, 1};
        checks++;
        if (!same(q4, e)) begin errors++; $display("FAIL ext_port4: got %s want %s", fmt(q4), fmt(e)); end
    endtask

    initial begin
        test_reset();
        test_crossings();
        test_zero();
        test_steady();
        test_reset_abort();
        test_extremes();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
